video_source_switcher: RTL and testbench
========================================

// Module: video_source_switcher
// PURPOSE
//  N-channel RGB source selector between the pixel generators and dvi_tx. Takes hs/vs/de from pixel_iterator.
//  Source changes take effect only at frame boundaries. Optional fade-out/fade-in runs over 2**FADE_LOG2 frames per leg.
//  Output is a registered 2-stage pipeline with timing signals delay-matched.
// PARAMETERS
//  CHANNELS       4     number of RGB sources (>=2)
//  COLOR_W        8     bits per colour component
//  SEL_W          3     sel width; values >= CHANNELS select black
//  FADE_LOG2      3     fade leg length = 2**FADE_LOG2 frames; 0 = hard cut at frame boundary
//  VS_POLARITY    1'b0  asserted level of vs_in/vs
//  HS_POLARITY    1'b0  asserted level of hs_in/hs
//  RESET_CHANNEL  0     active channel after reset
// PORTS
//  clk        in   1                   pixel clock
//  rst        in   1                   asynchronous, active-high reset
//  ce         in   1                   clock enable; low = every register holds
//  sel        in   SEL_W               requested source; asynchronous (switches)
//  src_r      in   CHANNELS*COLOR_W    channel i at [i*COLOR_W +: COLOR_W]
//  src_g      in   CHANNELS*COLOR_W    as src_r
//  src_b      in   CHANNELS*COLOR_W    as src_r
//  hs_in      in   1                   timing signal from pixel_iterator
//  vs_in      in   1                   timing signal from pixel_iterator
//  de_in      in   1                   timing signal from pixel_iterator
//  r, g, b    out  COLOR_W each        pixel out, aligned with hs/vs/de
//  hs, vs, de out  1 each              hs_in/vs_in/de_in delayed 2 cycles
//  active_ch  out  SEL_W               channel currently shown (CHANNELS = black)
//  busy       out  1                   high while state != IDLE
// BEHAVIOUR
//  Reset: r/g/b=0, hs=~HS_POLARITY, vs=~VS_POLARITY, de=0, active_ch=RESET_CHANNEL, gain=FULL, state=IDLE, busy=0.
//  sel path: 2-FF synchroniser per bit. req is updated only when the synchronised value equals its previous-cycle value.
//  req >= CHANNELS maps to index CHANNELS (black).
//  frame_tick: one-cycle pulse on vs_in transition into VS_POLARITY, with ce=1. All state/gain updates occur only on frame_tick.
//  Gain: FADE_LOG2+1 bits, range 0..FULL=2**FADE_LOG2. Pixel = (src*gain) >> FADE_LOG2.
//  Product width is COLOR_W+FADE_LOG2+1. gain=FULL returns src exactly; gain=0 returns 0.
//  FSM (FADE_LOG2>0):
//   IDLE:     on frame_tick with req!=active_ch -> FADE_OUT, gain-=1.
//   FADE_OUT: on frame_tick: if req==active_ch -> FADE_IN, gain+=1 (reverse, no jump).
//             Else if gain==1 -> gain=0, active_ch=req, FADE_IN. Else gain-=1.
//   FADE_IN:  on frame_tick: if req!=active_ch -> FADE_OUT, gain-=1.
//             Else if gain==FULL-1 -> gain=FULL, IDLE. Else gain+=1.
//   Full switch = 2*FULL frame_ticks. A req change mid-FADE_OUT retargets without restarting.
//  FADE_LOG2==0: IDLE only; on frame_tick with req!=active_ch, active_ch=req; busy stays 0.
//  Pipeline: S1 registers the muxed src (by active_ch) and the timing signals. S2 registers the scaled pixel and the timing signals.
//   Latency is exactly 2 enabled cycles, input to output.
//   r/g/b forced 0 in S2 when S1 de=0.
//  active_ch/gain change at frame_tick, i.e. during vsync (de=0). No visible mid-frame tear.
//  ce=0: pipeline, synchroniser, FSM all hold. A vs edge under ce=0 is not a frame_tick.
//  rst mid-fade: immediate return to reset values; no residual fade.
// STRUCTURE
//  video_pkg: typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} switch_state_t.
//  video_pkg: function sel_width(CHANNELS) = $clog2(CHANNELS+1).
//  Sub-module video_fader (COLOR_W, FADE_LOG2): registered 3-component multiply-shift, 1 cycle, ce-gated, async rst.
//  Synchroniser: reuse existing synchronizer per sel bit.
// TESTING
//  1 Reset, CHANNELS=4, FADE_LOG2=3, src0=8'h80 all comps, de_in=1 -> r=g=b=8'h80 from cycle 2; active_ch=0, busy=0.
//  2 sel 0->2 mid-frame -> no output change until next frame_tick.
//    Then gain 7,6,..,0 (r=8'h70 at gain 7), switch to 2, gain 1..8. busy low after 16 ticks.
//  3 During FADE_OUT at gain 4, sel back to 0 -> FADE_IN from gain 5, return to IDLE after 3 more ticks.
//    active_ch never changes.
//  4 sel=5 (>=CHANNELS) -> after fade-out, active_ch=4, r=g=b=0 with de=1.
//  5 FADE_LOG2=0: sel 1->3 -> cut at exactly the first frame_tick; hs/vs/de equal inputs delayed 2 cycles throughout.
//  6 ce low 10 cycles with a vs edge inside; rst pulse during FADE_IN -> outputs frozen under ce.
//    After rst: reset values, active_ch=RESET_CHANNEL.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and helpers for the video source switcher.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } switch_state_t;

  // Width able to encode every channel plus the extra "black" index.
  function automatic int unsigned sel_width(input int unsigned channels);
    return $clog2(channels + 1);
  endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchroniser for a single asynchronous bit, clock-enable gated.
module synchronizer #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {2{RESET_VAL}};
    end else if (ce_i) begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/video_fader.sv
// Registered RGB gain stage: out = (in * gain) >> FADE_LOG2, blanked when de_i is low.
module video_fader #(
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned FADE_LOG2 = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ce_i,
  input  logic                 de_i,
  input  logic [FADE_LOG2:0]   gain_i,
  input  logic [COLOR_W-1:0]   r_i,
  input  logic [COLOR_W-1:0]   g_i,
  input  logic [COLOR_W-1:0]   b_i,
  output logic [COLOR_W-1:0]   r_o,
  output logic [COLOR_W-1:0]   g_o,
  output logic [COLOR_W-1:0]   b_o
);

  localparam int unsigned ProdW = COLOR_W + FADE_LOG2 + 1;

  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [FADE_LOG2:0] g);
    logic [ProdW-1:0] p;
    p = ProdW'(c) * ProdW'(g);
    return COLOR_W'(p >> FADE_LOG2);
  endfunction

  logic [COLOR_W-1:0] r_d, g_d, b_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de_i) begin
      r_d = scale(r_i, gain_i);
      g_d = scale(g_i, gain_i);
      b_d = scale(b_i, gain_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (ce_i) begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r_o = r_q;
  assign g_o = g_q;
  assign b_o = b_q;

endmodule

// File: rtl/video_source_switcher.sv
// N-channel RGB source selector; switches only at frame start, with optional
// multi-frame fade-out/fade-in, behind a 2-stage delay-matched pipeline.
module video_source_switcher
  import video_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned COLOR_W       = 8,
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned FADE_LOG2     = 3,
  parameter logic        VS_POLARITY   = 1'b0,
  parameter logic        HS_POLARITY   = 1'b0,
  parameter int unsigned RESET_CHANNEL = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic [SEL_W-1:0]            sel,
  input  logic [CHANNELS*COLOR_W-1:0] src_r,
  input  logic [CHANNELS*COLOR_W-1:0] src_g,
  input  logic [CHANNELS*COLOR_W-1:0] src_b,
  input  logic                        hs_in,
  input  logic                        vs_in,
  input  logic                        de_in,
  output logic [COLOR_W-1:0]          r,
  output logic [COLOR_W-1:0]          g,
  output logic [COLOR_W-1:0]          b,
  output logic                        hs,
  output logic                        vs,
  output logic                        de,
  output logic [SEL_W-1:0]            active_ch,
  output logic                        busy
);

  localparam int unsigned      GainW    = FADE_LOG2 + 1;
  localparam logic [GainW-1:0] GainOne  = GainW'(1);
  localparam logic [GainW-1:0] GainFull = GainOne << FADE_LOG2;
  localparam logic [SEL_W-1:0] ResetCh  = SEL_W'(RESET_CHANNEL);
  localparam logic [SEL_W-1:0] BlackCh  = SEL_W'(CHANNELS);

  // Selection request path
  logic [SEL_W-1:0] sel_sync, sel_prev_q, req_q, req_idx;

  for (genvar i = 0; i < SEL_W; i++) begin : g_sel_sync
    synchronizer #(
      .RESET_VAL(ResetCh[i])
    ) u_sync (
      .clk_i(clk),
      .rst_i(rst),
      .ce_i (ce),
      .d_i  (sel[i]),
      .q_o  (sel_sync[i])
    );
  end

  // Only accept a request that held steady across two samples (debounces bit skew).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_prev_q <= ResetCh;
      req_q      <= ResetCh;
    end else if (ce) begin
      sel_prev_q <= sel_sync;
      if (sel_sync == sel_prev_q) req_q <= sel_sync;
    end
  end

  assign req_idx = (32'(req_q) >= CHANNELS) ? BlackCh : req_q;

  // Frame tick on entry into vsync
  logic vs_prev_q, frame_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev_q <= ~VS_POLARITY;
    end else if (ce) begin
      vs_prev_q <= vs_in;
    end
  end

  assign frame_tick = ce && (vs_in == VS_POLARITY) && (vs_prev_q != VS_POLARITY);

  // Switch FSM
  switch_state_t    state_q, state_d;
  logic [GainW-1:0] gain_q, gain_d;
  logic [SEL_W-1:0] active_q, active_d;

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    active_d = active_q;
    if (frame_tick) begin
      if (FADE_LOG2 == 0) begin
        if (req_idx != active_q) active_d = req_idx;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_idx != active_q) begin
              state_d = FADE_OUT;
              gain_d  = gain_q - GainOne;
            end
          end
          FADE_OUT: begin
            if (req_idx == active_q) begin
              state_d = FADE_IN;
              gain_d  = gain_q + GainOne;
            end else if (gain_q == GainOne) begin
              gain_d   = '0;
              active_d = req_idx;
              state_d  = FADE_IN;
            end else begin
              gain_d = gain_q - GainOne;
            end
          end
          FADE_IN: begin
            if (req_idx != active_q) begin
              // Already black: retarget in place rather than underflow the gain.
              if (gain_q == '0) begin
                active_d = req_idx;
              end else begin
                state_d = FADE_OUT;
                gain_d  = gain_q - GainOne;
              end
            end else if (gain_q == GainFull - GainOne) begin
              gain_d  = GainFull;
              state_d = IDLE;
            end else begin
              gain_d = gain_q + GainOne;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gain_q   <= GainFull;
      active_q <= ResetCh;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      active_q <= active_d;
    end
  end

  // Stage 1: source mux and timing
  logic [COLOR_W-1:0] mux_r, mux_g, mux_b;
  logic [COLOR_W-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic               s1_hs_q, s1_vs_q, s1_de_q;
  logic               s2_hs_q, s2_vs_q, s2_de_q;

  always_comb begin
    mux_r = '0;
    mux_g = '0;
    mux_b = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (active_q == SEL_W'(i)) begin
        mux_r = src_r[i*COLOR_W +: COLOR_W];
        mux_g = src_g[i*COLOR_W +: COLOR_W];
        mux_b = src_b[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r_q  <= '0;
      s1_g_q  <= '0;
      s1_b_q  <= '0;
      s1_hs_q <= ~HS_POLARITY;
      s1_vs_q <= ~VS_POLARITY;
      s1_de_q <= 1'b0;
      s2_hs_q <= ~HS_POLARITY;
      s2_vs_q <= ~VS_POLARITY;
      s2_de_q <= 1'b0;
    end else if (ce) begin
      s1_r_q  <= mux_r;
      s1_g_q  <= mux_g;
      s1_b_q  <= mux_b;
      s1_hs_q <= hs_in;
      s1_vs_q <= vs_in;
      s1_de_q <= de_in;
      s2_hs_q <= s1_hs_q;
      s2_vs_q <= s1_vs_q;
      s2_de_q <= s1_de_q;
    end
  end

  // Stage 2: gain
  video_fader #(
    .COLOR_W  (COLOR_W),
    .FADE_LOG2(FADE_LOG2)
  ) u_fader (
    .clk_i (clk),
    .rst_i (rst),
    .ce_i  (ce),
    .de_i  (s1_de_q),
    .gain_i(gain_q),
    .r_i   (s1_r_q),
    .g_i   (s1_g_q),
    .b_i   (s1_b_q),
    .r_o   (r),
    .g_o   (g),
    .b_o   (b)
  );

  assign hs        = s2_hs_q;
  assign vs        = s2_vs_q;
  assign de        = s2_de_q;
  assign active_ch = active_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_video_source_switcher.sv
// Directed bench: fading switcher (FADE_LOG2=3) and hard-cut switcher (FADE_LOG2=0) side by side.
module tb_video_source_switcher;

  logic        clk = 1'b0;
  logic        rst, ce;
  logic [2:0]  sel;
  logic [31:0] src_r, src_g, src_b;
  logic        hs_in, vs_in, de_in;

  logic [7:0]  r, g, b, r0, g0, b0;
  logic        hs, vs, de, hs0, vs0, de0, busy, busy0;
  logic [2:0]  active_ch, active_ch0;

  int total = 0;
  int bad   = 0;

  logic [7:0] cr [0:4];
  logic [7:0] cg [0:4];
  logic [7:0] cb [0:4];

  always #5 clk = ~clk;

  video_source_switcher #(.FADE_LOG2(3)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sel(sel),
    .src_r(src_r), .src_g(src_g), .src_b(src_b),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de),
    .active_ch(active_ch), .busy(busy)
  );

  video_source_switcher #(.FADE_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .sel(sel),
    .src_r(src_r), .src_g(src_g), .src_b(src_b),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .r(r0), .g(g0), .b(b0), .hs(hs0), .vs(vs0), .de(de0),
    .active_ch(active_ch0), .busy(busy0)
  );

  function automatic logic [7:0] scale(input logic [7:0] v, input int gn);
    return 8'((int'(v) * gn) >> 3);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One vsync (asserted low) with blanking, then several active cycles.
  task automatic frame();
    de_in = 1'b0;
    vs_in = 1'b0;
    step(3);
    vs_in = 1'b1;
    step(1);
    de_in = 1'b1;
    step(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; sel = 3'd0;
    hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0;
    step(2);
    total++; if (r !== 8'h00 || g !== 8'h00 || b !== 8'h00) begin bad++;
      $display("FAIL reset_rgb: got %h %h %h want 00 00 00", r, g, b); end
    total++; if ({hs, vs, de} !== 3'b110) begin bad++;
      $display("FAIL reset_timing: got %b want 110", {hs, vs, de}); end
    total++; if (active_ch !== 3'd0 || busy !== 1'b0) begin bad++;
      $display("FAIL reset_state: got ch=%0d busy=%b want ch=0 busy=0", active_ch, busy); end
    de_in = 1'b1;
    rst   = 1'b0;
    step(1);
    total++; if (r !== 8'h00) begin bad++;
      $display("FAIL latency_1: got %h want 00", r); end
    step(1);
    total++; if (r !== 8'h80 || g !== 8'h80 || b !== 8'h80 || de !== 1'b1) begin bad++;
      $display("FAIL latency_2: got %h %h %h de=%b want 80 80 80 de=1", r, g, b, de); end
  endtask

  task automatic test_fade_switch();
    int gn, ch;
    sel = 3'd2;
    step(6);
    total++; if (r !== 8'h80 || active_ch !== 3'd0 || busy !== 1'b0) begin bad++;
      $display("FAIL midframe_hold: got r=%h ch=%0d busy=%b want 80 0 0", r, active_ch, busy); end
    for (int k = 1; k <= 16; k++) begin
      frame();
      gn = (k <= 8) ? 8 - k : k - 8;
      ch = (k < 8) ? 0 : 2;
      total++; if (active_ch !== 3'(ch) || busy !== (k < 16)) begin bad++;
        $display("FAIL fade_state k=%0d: got ch=%0d busy=%b want ch=%0d busy=%b",
                 k, active_ch, busy, ch, k < 16); end
      total++;
      if (r !== scale(cr[ch], gn) || g !== scale(cg[ch], gn) || b !== scale(cb[ch], gn)) begin
        bad++;
        $display("FAIL fade_rgb k=%0d: got %h %h %h want %h %h %h", k, r, g, b,
                 scale(cr[ch], gn), scale(cg[ch], gn), scale(cb[ch], gn)); end
    end
  endtask

  task automatic test_reverse();
    int gn;
    sel = 3'd0;
    step(6);
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) begin
        sel = 3'd2;
        step(6);
      end
      frame();
      gn = (k <= 4) ? 8 - k : k;
      total++; if (active_ch !== 3'd2 || busy !== (k < 8)) begin bad++;
        $display("FAIL reverse_state k=%0d: got ch=%0d busy=%b want ch=2 busy=%b",
                 k, active_ch, busy, k < 8); end
      total++; if (r !== scale(cr[2], gn)) begin bad++;
        $display("FAIL reverse_r k=%0d: got %h want %h", k, r, scale(cr[2], gn)); end
    end
  endtask

  task automatic test_black();
    logic [7:0] er;
    sel = 3'd5;
    step(6);
    for (int k = 1; k <= 16; k++) begin
      frame();
      er = (k < 8) ? scale(cr[2], 8 - k) : 8'h00;
      total++; if (active_ch !== ((k < 8) ? 3'd2 : 3'd4) || r !== er) begin bad++;
        $display("FAIL black_fade k=%0d: got ch=%0d r=%h want ch=%0d r=%h",
                 k, active_ch, r, (k < 8) ? 2 : 4, er); end
    end
    total++; if ({r, g, b} !== 24'h0 || de !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL black_final: got %h %h %h de=%b busy=%b want 00 00 00 de=1 busy=0",
               r, g, b, de, busy); end
  endtask

  task automatic test_hard_cut();
    logic [2:0] hist [0:23];
    logic [2:0] pat;
    sel = 3'd1;
    step(6);
    frame();
    total++; if (active_ch0 !== 3'd1 || {r0, g0, b0} !== 24'h402008 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL cut_first: got ch=%0d %h %h %h busy=%b want ch=1 40 20 08 busy=0",
               active_ch0, r0, g0, b0, busy0); end
    sel = 3'd3;
    step(6);
    total++; if (active_ch0 !== 3'd1 || r0 !== 8'h40) begin bad++;
      $display("FAIL cut_hold: got ch=%0d r=%h want ch=1 r=40", active_ch0, r0); end
    de_in = 1'b0;
    vs_in = 1'b0;
    total++; if (active_ch0 !== 3'd1) begin bad++;
      $display("FAIL cut_pre_tick: got ch=%0d want 1", active_ch0); end
    step(1);
    total++; if (active_ch0 !== 3'd3 || busy0 !== 1'b0) begin bad++;
      $display("FAIL cut_tick: got ch=%0d busy=%b want ch=3 busy=0", active_ch0, busy0); end
    step(2);
    vs_in = 1'b1;
    step(1);
    de_in = 1'b1;
    step(4);
    total++; if ({r0, g0, b0} !== 24'h336699) begin bad++;
      $display("FAIL cut_rgb: got %h %h %h want 33 66 99", r0, g0, b0); end
    for (int i = 0; i < 24; i++) begin
      pat = {1'(i ^ (i >> 2)), 1'((i % 7) >= 3), 1'(i >> 1)};
      {hs_in, vs_in, de_in} = pat;
      hist[i] = pat;
      if (i >= 2) begin
        total++; if ({hs0, vs0, de0} !== hist[i-2] || {hs, vs, de} !== hist[i-2]) begin bad++;
          $display("FAIL timing_delay i=%0d: got %b/%b want %b", i, {hs0, vs0, de0},
                   {hs, vs, de}, hist[i-2]); end
      end
      step(1);
    end
  endtask

  task automatic test_ce_rst();
    hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b1; sel = 3'd1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
    for (int k = 1; k <= 10; k++) frame();
    total++; if ({r, g, b} !== 24'h100802 || active_ch !== 3'd1 || busy !== 1'b1) begin bad++;
      $display("FAIL fadein_setup: got %h %h %h ch=%0d busy=%b want 10 08 02 ch=1 busy=1",
               r, g, b, active_ch, busy); end
    ce = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vs_in = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
      hs_in = 1'(i);
      de_in = 1'(i >> 1);
      step(1);
      total++;
      if ({r, g, b} !== 24'h100802 || {hs, vs, de} !== 3'b111 || active_ch !== 3'd1 ||
          busy !== 1'b1) begin
        bad++;
        $display("FAIL ce_freeze i=%0d: got %h %h %h %b ch=%0d busy=%b want 10 08 02 111 1 1",
                 i, r, g, b, {hs, vs, de}, active_ch, busy); end
    end
    hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b1;
    ce = 1'b1;
    step(4);
    total++; if (r !== 8'h10 || busy !== 1'b1) begin bad++;
      $display("FAIL ce_no_tick: got r=%h busy=%b want r=10 busy=1", r, busy); end
    rst = 1'b1;
    #1;
    total++; if ({r, g, b} !== 24'h0 || {hs, vs, de} !== 3'b110 || active_ch !== 3'd0 ||
                 busy !== 1'b0) begin bad++;
      $display("FAIL rst_midfade: got %h %h %h %b ch=%0d busy=%b want 00 00 00 110 0 0",
               r, g, b, {hs, vs, de}, active_ch, busy); end
    step(1);
    rst = 1'b0;
    step(2);
    total++; if ({r, g, b} !== 24'h808080 || active_ch !== 3'd0 || busy !== 1'b0) begin bad++;
      $display("FAIL rst_no_residual: got %h %h %h ch=%0d busy=%b want 80 80 80 0 0",
               r, g, b, active_ch, busy); end
  endtask

  initial begin
    src_r = {8'h33, 8'hF0, 8'h40, 8'h80};
    src_g = {8'h66, 8'h78, 8'h20, 8'h80};
    src_b = {8'h99, 8'h10, 8'h08, 8'h80};
    cr[0] = 8'h80; cr[1] = 8'h40; cr[2] = 8'hF0; cr[3] = 8'h33; cr[4] = 8'h00;
    cg[0] = 8'h80; cg[1] = 8'h20; cg[2] = 8'h78; cg[3] = 8'h66; cg[4] = 8'h00;
    cb[0] = 8'h80; cb[1] = 8'h08; cb[2] = 8'h10; cb[3] = 8'h99; cb[4] = 8'h00;
    test_reset();
    test_fade_switch();
    test_reverse();
    test_black();
    test_hard_cut();
    test_ce_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
